// File: rtl/backend_cfg_serializer.sv
// Backend serial configuration initiator: reset sequencing, ready wait,
// MSB-first frame shifting on sclk/sdout and vco1_fast flag return.
module backend_cfg_serializer #(
    parameter int FRAME_BITS    = 5,
    parameter int CLK_DIV       = 2,
    parameter int RST_CYCLES    = 8,
    parameter int READY_TIMEOUT = 256,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_data,
    input  logic                  i_ready,
    input  logic                  i_vco1_fast,
    output logic                  o_resetbAll,
    output logic                  o_sclk,
    output logic                  o_sdout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_link_up,
    output logic                  o_timeout,
    output logic                  o_vco1_fast
);

    localparam int MAX_A = (RST_CYCLES > READY_TIMEOUT) ? RST_CYCLES : READY_TIMEOUT;
    localparam int MAX_B = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int BW    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(READY_TIMEOUT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_RDY,
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n, shifted;
    logic                  sclk_n, sdout_n, timeout_n, done_n;
    logic                  rdy_meta, rdy_s, vco_meta;

    assign shifted = shreg << 1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        sclk_n    = o_sclk;
        sdout_n   = o_sdout;
        timeout_n = o_timeout;
        unique case (state)
            RST_HOLD: begin
                sclk_n  = 1'b0;
                sdout_n = 1'b0;
                if (cnt == RST_LAST) begin
                    state_n = WAIT_RDY;
                    cnt_n   = '0;
                end
            end
            WAIT_RDY: begin
                // Ready arriving on the last count wins over the timeout.
                if (rdy_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_n   = RST_HOLD;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end
            end
            IDLE: begin
                cnt_n   = '0;
                sclk_n  = 1'b0;
                sdout_n = 1'b0;
                if (!rdy_s) begin
                    state_n = RST_HOLD;
                end else if (i_start) begin
                    state_n   = SHIFT;
                    shreg_n   = i_data;
                    sdout_n   = i_data[FRAME_BITS-1];
                    bit_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (!rdy_s) begin
                    state_n = RST_HOLD;
                    cnt_n   = '0;
                    sclk_n  = 1'b0;
                    sdout_n = 1'b0;
                end else if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!o_sclk) begin
                        sclk_n = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_n = GAP;
                        sclk_n  = 1'b0;
                        sdout_n = 1'b0;
                    end else begin
                        // Next bit is launched together with the falling edge.
                        bit_cnt_n = bit_cnt + 1'b1;
                        shreg_n   = shifted;
                        sdout_n   = shifted[FRAME_BITS-1];
                        sclk_n    = 1'b0;
                    end
                end
            end
            GAP: begin
                sclk_n  = 1'b0;
                sdout_n = 1'b0;
                if (!rdy_s) begin
                    state_n = RST_HOLD;
                    cnt_n   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = RST_HOLD;
                cnt_n   = '0;
                sclk_n  = 1'b0;
                sdout_n = 1'b0;
            end
        endcase
        done_n = (state_n == GAP) && (cnt_n == GAP_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= RST_HOLD;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rdy_meta    <= 1'b0;
            rdy_s       <= 1'b0;
            vco_meta    <= 1'b0;
            o_vco1_fast <= 1'b0;
            o_resetbAll <= 1'b0;
            o_sclk      <= 1'b0;
            o_sdout     <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_link_up   <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            rdy_meta    <= i_ready;
            rdy_s       <= rdy_meta;
            vco_meta    <= i_vco1_fast;
            o_vco1_fast <= vco_meta;
            o_resetbAll <= (state_n != RST_HOLD);
            o_sclk      <= sclk_n;
            o_sdout     <= sdout_n;
            o_busy      <= (state_n != IDLE);
            o_done      <= done_n;
            o_link_up   <= (state inside {IDLE, SHIFT, GAP});
            o_timeout   <= timeout_n;
        end
    end

endmodule

// File: doc/backend_cfg_serializer.md
Name: backend_cfg_serializer

Overview:
- FPGA-side initiator for the backend serial configuration interface.
- Sequences the backend reset (o_resetbAll), waits for backend i_ready, then shifts configuration frames MSB-first on o_sclk/o_sdout. Frame bits are {gainA1[2:0], gainA2[1:0]} by default.
- Returns a synchronized copy of the backend's vco1_fast flag to FPGA logic.
- Sits in the FPGA model, facing the backend's i_resetbAll/i_sclk/i_sdin/o_ready/o_vco1_fast.

Parameters:
- FRAME_BITS, 5: payload bits per frame.
- CLK_DIV, 2: i_clk cycles per o_sclk phase (sclk period = 2*CLK_DIV cycles); must be ≥1.
- RST_CYCLES, 8: cycles o_resetbAll is held low after reset or abort.
- READY_TIMEOUT, 256: cycles to wait for synchronized ready before declaring timeout.
- GAP_CYCLES, 4: idle cycles after the last sclk falling edge before o_done; ≥1.

Ports:
- i_clk  input  1  main clock.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  frame request; accepted only in IDLE.
- i_data  input  FRAME_BITS  payload; captured on acceptance.
- i_ready  input  1  backend ready; asynchronous to i_clk.
- i_vco1_fast  input  1  backend VCO1 comparator flag; asynchronous.
- o_resetbAll  output  1  active-low backend reset.
- o_sclk  output  1  serial clock; idles low.
- o_sdout  output  1  serial data; changes only while o_sclk is low.
- o_busy  output  1  high outside IDLE.
- o_done  output  1  one-cycle pulse at frame completion.
- o_link_up  output  1  high in IDLE, SHIFT, GAP.
- o_timeout  output  1  sticky; set on ready timeout; cleared only by i_reset.
- o_vco1_fast  output  1  2-flop-synchronized i_vco1_fast.

Behaviour:
- **Synchronization:** i_ready and i_vco1_fast each pass through 2 flops. rdy_s is the synchronized ready; o_vco1_fast lags its input by 2 cycles.
- **Reset values:** o_resetbAll=0, o_sclk=0, o_sdout=0, o_busy=1, o_done=0, o_link_up=0, o_timeout=0, o_vco1_fast=0. Synchronizer flops=0; state=RST_HOLD; all counters 0.
- **RST_HOLD:**
  - o_resetbAll=0 for exactly RST_CYCLES cycles, then go to WAIT_RDY.
  - o_resetbAll is registered high on the first WAIT_RDY cycle.
- **WAIT_RDY:**
  - Counts cycles. If rdy_s=1, go to IDLE.
  - If the count reaches READY_TIMEOUT without ready: set o_timeout, return to RST_HOLD. This retries indefinitely.
  - rdy_s=1 on the timeout cycle wins; no timeout is flagged.
- **IDLE:**
  - o_busy=0, o_sclk=0, o_sdout=0.
  - If i_start=1 at cycle T: capture i_data into the shift register, go to SHIFT at T+1.
- **SHIFT:**
  - Bit k (k=0 is the MSB) is driven on o_sdout over cycles T+1+2k·CLK_DIV through T+(2k+2)·CLK_DIV.
  - o_sclk is low for the first CLK_DIV cycles of each bit and high for the next CLK_DIV cycles.
  - The backend samples on the sclk rising edge.
  - After bit FRAME_BITS-1's high phase: o_sclk=0, o_sdout=0, go to GAP.
- **GAP:** GAP_CYCLES cycles with sclk low, then a one-cycle o_done pulse on the transition to IDLE.
  - o_done is high at cycle T+1+2·FRAME_BITS·CLK_DIV+GAP_CYCLES-1.
  - o_busy drops the following cycle.
- **i_start outside IDLE:** ignored, never queued. i_start held high in IDLE starts back-to-back frames.
- **Abort:** rdy_s=0 in IDLE, SHIFT or GAP means:
  - o_sclk=0 and o_sdout=0 next cycle; no o_done.
  - Go to RST_HOLD, which re-pulses o_resetbAll.
  - A partial frame is never completed.
- **i_reset mid-frame:** all outputs return to reset values on the next edge.
- **o_link_up:** registered from state.
- **Counters:** width clog2 of the largest bound (minimum 1 bit). No wrap is possible; each counter is cleared on every state entry.

Test Plan (FRAME_BITS=5, CLK_DIV=2, RST_CYCLES=8, GAP_CYCLES=4):
- **Reset release:** i_reset high 3 cycles then low, i_ready tied 1 → o_resetbAll low exactly 8 cycles after reset deassert, then high; o_link_up high 2–3 cycles later; o_timeout=0.
- **Single frame:** start with i_data=5'b10110 →
  - sdout bits 1,0,1,1,0, each stable 4 cycles with sclk low 2 / high 2.
  - 5 rising edges; o_done pulse 24 cycles after start acceptance; o_busy high throughout.
  - Bench shift register captures 10110.
- **Back-to-back frames:** i_start held high with data 5'b11111 then 5'b00001 → two complete frames separated by GAP plus 1 IDLE cycle; exactly 10 rising edges; two o_done pulses.
- **Ignored start:** i_start pulsed during SHIFT → no effect; frame content unchanged; only one o_done.
- **Ready timeout:** i_ready tied 0, READY_TIMEOUT=16 → o_timeout sets after 16 WAIT_RDY cycles; o_resetbAll re-pulses low 8 cycles, repeatedly. Raising i_ready later reaches IDLE with o_timeout still 1.
- **Abort and flag sync:**
  - i_ready dropped after the third rising edge → sclk/sdout low within 3 cycles, no o_done, o_resetbAll pulses, frame restarts only on a new i_start.
  - i_vco1_fast toggle appears on o_vco1_fast exactly 2 cycles later.
